// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between the spi2adc initiator (master) and the MCP3002-style responder (slave).
`timescale 1ns/1ps
interface adc_spi_responder_if;
   logic adc_cs;
   logic adc_sck;
   logic sdata_to_adc;
   logic sdata_from_adc;
   logic sdo_oe;

   modport master (
      output adc_cs, adc_sck, sdata_to_adc,
      input  sdata_from_adc, sdo_oe
   );

   modport slave (
      input  adc_cs, adc_sck, sdata_to_adc,
      output sdata_from_adc, sdo_oe
   );
endinterface

// File: rtl/adc_spi_responder.sv
// MCP3002-compatible SPI responder: oversamples the SPI pins on sysclk, decodes the
// start/SGL/ODD/MSBF command and shifts a 10-bit (optionally differential) result back.
`timescale 1ns/1ps
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                sysclk,
   input  logic                rst_n,
   input  logic [9:0]          ch0_data,
   input  logic [9:0]          ch1_data,
   adc_spi_responder_if.slave  spi,
   output logic                conv_done,
   output logic [9:0]          last_result,
   output logic                frame_err
);

   typedef enum logic [2:0] {
      IDLE, WAIT_START, CFG, NULL_BIT, DATA_MSB, DATA_LSB, TRAIL
   } state_t;

   function automatic logic [9:0] clamp_diff(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d < 11'sd0) ? 10'd0 : d[9:0];
   endfunction

   logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
   logic                   cs_s, sck_s, sdi_s, sck_p1;
   logic                   sck_rise, sck_fall;
   state_t                 state;
   logic [3:0]             bitcnt;
   logic                   sdo_q, oe_q;
   logic                   sgl_q, odd_q, msbf_q;
   logic [9:0]             result_q, next_result;
   logic                   cfg_rise;

   // Synchronizer chains and SCK edge detection
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync  <= '1;
         sck_sync <= '0;
         sdi_sync <= '0;
         sck_p1   <= 1'b0;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi.adc_cs};
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.adc_sck};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi.sdata_to_adc};
         sck_p1   <= sck_sync[SYNC_STAGES-1];
      end
   end

   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_p1;
   assign sck_fall = ~sck_s & sck_p1;
   assign cfg_rise = (state == CFG) && !cs_s && sck_rise;

   always_comb begin
      next_result = ch0_data;
      if (sgl_q)
         next_result = odd_q ? ch1_data : ch0_data;
      else
         next_result = odd_q ? clamp_diff(ch1_data, ch0_data) : clamp_diff(ch0_data, ch1_data);
   end

   // Command fields and the latched conversion are pure data: no reset needed
   always_ff @(posedge sysclk) begin
      if (cfg_rise) begin
         case (bitcnt)
            4'd0:    sgl_q <= sdi_s;
            4'd1:    odd_q <= sdi_s;
            default: begin
               msbf_q   <= sdi_s;
               result_q <= next_result;
            end
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bitcnt      <= 4'd0;
         sdo_q       <= 1'b0;
         oe_q        <= 1'b0;
         conv_done   <= 1'b0;
         last_result <= 10'd0;
         frame_err   <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         if (cs_s) begin
            // CS high wins over any coincident SCK edge
            state <= IDLE;
            oe_q  <= 1'b0;
            sdo_q <= 1'b0;
            if (state inside {CFG, NULL_BIT, DATA_MSB, DATA_LSB})
               frame_err <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  state <= WAIT_START;
                  oe_q  <= 1'b1;
               end
               WAIT_START: begin
                  if (sck_rise && sdi_s) begin
                     state  <= CFG;
                     bitcnt <= 4'd0;
                  end
               end
               CFG: begin
                  if (sck_rise) begin
                     if (bitcnt == 4'd2) state <= NULL_BIT;
                     else                bitcnt <= bitcnt + 4'd1;
                  end
               end
               NULL_BIT: begin
                  if (sck_fall) begin
                     sdo_q  <= 1'b0;
                     state  <= DATA_MSB;
                     bitcnt <= 4'd9;
                  end
               end
               DATA_MSB: begin
                  if (sck_fall) begin
                     sdo_q <= result_q[bitcnt];
                     if (bitcnt != 4'd0) begin
                        bitcnt <= bitcnt - 4'd1;
                     end else if (msbf_q) begin
                        state       <= TRAIL;
                        conv_done   <= 1'b1;
                        last_result <= result_q;
                     end else begin
                        state  <= DATA_LSB;
                        bitcnt <= 4'd1;
                     end
                  end
               end
               DATA_LSB: begin
                  if (sck_fall) begin
                     sdo_q <= result_q[bitcnt];
                     if (bitcnt == 4'd9) begin
                        state       <= TRAIL;
                        conv_done   <= 1'b1;
                        last_result <= result_q;
                     end else begin
                        bitcnt <= bitcnt + 4'd1;
                     end
                  end
               end
               TRAIL: begin
                  if (sck_fall) sdo_q <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign spi.sdata_from_adc = sdo_q;
   assign spi.sdo_oe         = oe_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as the SPI initiator and checks SDO streams,
// conv_done, last_result and frame_err against a behavioural MCP3002 model.
`timescale 1ns/1ps
module tb_adc_spi_responder;
   localparam int SYNC = 2;
   localparam int H    = 6;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic [9:0] ch0, ch1;
   logic       conv_done;
   logic [9:0] last_result;
   logic       frame_err;

   adc_spi_responder_if spi();

   adc_spi_responder #(.SYNC_STAGES(SYNC)) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .ch0_data    (ch0),
      .ch1_data    (ch1),
      .spi         (spi),
      .conv_done   (conv_done),
      .last_result (last_result),
      .frame_err   (frame_err)
   );

   always #10 sysclk = ~sysclk;

   int n_vec = 0;
   int n_err = 0;
   int cd_total = 0;
   bit err_exp = 1'b0;

   always @(posedge sysclk) if (conv_done === 1'b1) cd_total <= cd_total + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   function automatic logic [9:0] model(input bit sgl, input bit odd,
                                        input logic [9:0] c0, input logic [9:0] c1);
      int d;
      if (sgl) d = odd ? int'(c1) : int'(c0);
      else     d = odd ? int'(c1) - int'(c0) : int'(c0) - int'(c1);
      if (d < 0) d = 0;
      return d[9:0];
   endfunction

   // Bit seen on SDO during clock j after the MSBF clock: null, MSB-first data, optional LSB tail, zeros
   function automatic logic exp_bit(input logic [9:0] r, input bit msbf, input int j);
      if (j >= 1 && j <= 10) return r[10-j];
      if (!msbf && j >= 11 && j <= 19) return r[j-10];
      return 1'b0;
   endfunction

   task automatic sck_cycle(input logic sdi, output logic sdo_seen);
      spi.sdata_to_adc = sdi;
      tick(H);
      sdo_seen = spi.sdata_from_adc;
      spi.adc_sck = 1'b1;
      tick(H);
      spi.adc_sck = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_sdo"},   32'(spi.sdata_from_adc), 32'd0);
      chk({tag, "_oe"},    32'(spi.sdo_oe),         32'd0);
      chk({tag, "_done"},  32'(conv_done),          32'd0);
      chk({tag, "_last"},  32'(last_result),        32'd0);
      chk({tag, "_ferr"},  32'(frame_err),          32'd0);
   endtask

   // kill_kind: 0 = complete frame, 1 = CS abort, 2 = async reset pulse; applied before clock kill_at
   task automatic run_frame(input bit sgl, input bit odd, input bit msbf,
                            input logic [9:0] c0, input logic [9:0] c1,
                            input int lead, input int kill_at, input int kill_kind);
      logic [9:0]  exp_r;
      logic [31:0] got_seq, exp_seq;
      logic        b;
      int          nbits, start, nsamp;
      ch0 = c0;
      ch1 = c1;
      exp_r = model(sgl, odd, c0, c1);
      start = cd_total;
      got_seq = '0;
      exp_seq = '0;
      nsamp = 0;
      spi.adc_cs = 1'b0;
      tick(H);
      chk("oe_cs_low", 32'(spi.sdo_oe), 32'd1);
      for (int i = 0; i < lead; i++) sck_cycle(1'b0, b);
      sck_cycle(1'b1, b);
      sck_cycle(sgl, b);
      sck_cycle(odd, b);
      sck_cycle(msbf, b);
      ch0 = 10'($urandom);
      ch1 = 10'($urandom);
      nbits = msbf ? 13 : 22;
      for (int j = 0; j < nbits; j++) begin
         if (kill_kind != 0 && j == kill_at) break;
         sck_cycle(1'b0, b);
         got_seq = {got_seq[30:0], b};
         exp_seq = {exp_seq[30:0], exp_bit(exp_r, msbf, j)};
         nsamp++;
      end
      chk("sdo_seq", got_seq, exp_seq);
      if (kill_kind == 1) begin
         spi.adc_cs = 1'b1;
         tick(SYNC + 1);
         err_exp = 1'b1;
         chk("oe_abort",   32'(spi.sdo_oe), 32'd0);
         chk("ferr_abort", 32'(frame_err),  32'd1);
         chk("done_abort", 32'(cd_total - start), 32'd0);
         tick(2);
      end else if (kill_kind == 2) begin
         #3 rst_n = 1'b0;
         #1 check_reset_values("rst_mid");
         rst_n = 1'b1;
         err_exp = 1'b0;
         spi.adc_cs = 1'b1;
         tick(SYNC + 3);
      end else begin
         tick(2);
         chk("done_cnt", 32'(cd_total - start), 32'd1);
         chk("last_res", 32'(last_result), 32'(exp_r));
         chk("ferr",     32'(frame_err),   32'(err_exp));
         spi.adc_cs = 1'b1;
         tick(SYNC + 2);
         chk("oe_cs_high", 32'(spi.sdo_oe), 32'd0);
      end
   endtask

   initial begin
      spi.adc_cs = 1'b1;
      spi.adc_sck = 1'b0;
      spi.sdata_to_adc = 1'b0;
      ch0 = '0;
      ch1 = '0;
      rst_n = 1'b0;
      tick(3);
      check_reset_values("reset");
      rst_n = 1'b1;
      tick(3);

      run_frame(1'b1, 1'b1, 1'b1, 10'h000, 10'h2A5, 0, -1, 0);
      run_frame(1'b1, 1'b0, 1'b1, 10'h001, 10'h3FF, 1, -1, 0);
      run_frame(1'b0, 1'b0, 1'b1, 10'h100, 10'h180, 0, -1, 0);
      run_frame(1'b0, 1'b1, 1'b1, 10'h100, 10'h180, 2, -1, 0);
      run_frame(1'b1, 1'b0, 1'b0, 10'h201, 10'h0F0, 0, -1, 0);
      run_frame(1'b1, 1'b1, 1'b1, 10'h155, 10'h2AA, 0, 3, 1);
      run_frame(1'b1, 1'b0, 1'b1, 10'h3C3, 10'h111, 1, -1, 0);
      run_frame(1'b1, 1'b1, 1'b0, 10'h0AB, 10'h3FE, 0, 5, 2);
      run_frame(1'b1, 1'b1, 1'b1, 10'h0AB, 10'h3FE, 0, -1, 0);

      for (int k = 0; k < 40; k++) begin
         run_frame(1'($urandom), 1'($urandom), 1'($urandom),
                   10'($urandom), 10'($urandom), int'($urandom_range(0, 2)), -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI slave model of the MCP3002 2-channel 10-bit ADC: the responder end of the spi2adc initiator.
- Samples SDI/SCK/CS with the system clock, decodes the 4-bit command and shifts a 10-bit conversion result back on SDO.
- Used in simulation benches and on-FPGA loopback tests to drive spi2adc with known sample values instead of the physical ADC.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sck/cs_n/sdi; legal values 2 or 3.

Ports:
- sysclk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- ch0_data  in  10  analogue value presented on CH0
- ch1_data  in  10  analogue value presented on CH1
- adc_cs  in  1  chip select from initiator, active low
- adc_sck  in  1  serial clock from initiator
- sdata_to_adc  in  1  command bits from initiator
- sdata_from_adc  out  1  serial result to initiator
- sdo_oe  out  1  high when sdata_from_adc is driven; low means hi-Z
- conv_done  out  1  one-sysclk pulse after the last data bit of a frame
- last_result  out  10  result of the most recent conversion
- frame_err  out  1  sticky; set on a CS abort mid-frame, cleared by reset

Behaviour:
- Reset, asynchronous: state=IDLE, sdata_from_adc=0, sdo_oe=0, conv_done=0, last_result=0, frame_err=0, synchronizers=1 for cs and 0 for sck/sdi.
- Inputs pass through SYNC_STAGES flops. Rising and falling edges of SCK are detected on the synchronized signal.
- SCK high and low phases must each be at least SYNC_STAGES+2 sysclk. Slower SCK is legal; faster SCK is unsupported.
- Synchronized cs high forces state=IDLE and sdo_oe=0 on the next sysclk from any state.
  - If this occurs in CFG, NULL or DATA states, frame_err is set.
- sdo_oe=1 from CS fall until CS rise. sdata_from_adc is 0 except in the DATA states.
- Bits are sampled on SCK rising edges. SDO is updated on SCK falling edges, at most SYNC_STAGES+2 sysclk after the pin edge.
- IDLE: on cs low, go to WAIT_START.
- WAIT_START: leading 0s on rising edges are ignored. The first 1 goes to CFG with bitcnt=0.
- CFG: on 3 rising edges, capture SGL, ODD, MSBF in that order.
  - On the MSBF rising edge, compute and latch the result.
    - SGL=1: result = ODD ? ch1_data : ch0_data.
    - SGL=0: ODD=0 gives ch0−ch1, ODD=1 gives ch1−ch0. Use 11-bit subtraction and clamp negative values to 0.
  - Go to NULL.
- NULL: the next falling edge drives 0 (null bit), then go to DATA_MSB with bitcnt=9.
- DATA_MSB: each subsequent falling edge drives result[bitcnt] and decrements bitcnt.
  - The edge after bit 0 is driven:
    - MSBF=1: go to TRAIL.
    - MSBF=0: go to DATA_LSB with bitcnt=1.
- DATA_LSB: falling edges drive result[1]..result[9] in ascending order, then go to TRAIL. Bit 0 is not repeated.
- Entry to TRAIL: conv_done pulses for 1 sysclk and last_result=result.
- TRAIL: drive 0 on all further falling edges until cs rises.
- Edges on SCK while cs is high are ignored. A CS rise at the same sysclk as an SCK edge: CS wins and the edge is discarded.
- ch0/ch1 changes after the latch instant do not affect the frame in progress.

Test Plan:
- Single-ended CH1, MSBF: ch1_data=10'h2A5, spi2adc started with channel=1 → spi2adc data_valid with data_from_adc=10'h2A5; conv_done pulses once; last_result=10'h2A5; frame_err=0.
- CH0 select: ch0_data=10'h001, ch1_data=10'h3FF, command start,SGL=1,ODD=0,MSBF=1 → SDO after the null bit is 0000000001.
- Differential clamp: SGL=0, ODD=0, ch0=10'h100, ch1=10'h180 → result 0, last_result=0. With ODD=1 → 10'h080.
- LSB-first tail: MSBF=0, ch0=10'h201 → SDO data sequence 1000000001 followed by 000000001 (result[1]..result[9]).
- Abort: cs raised after 2 data bits → sdo_oe=0 within SYNC_STAGES+1 sysclk, frame_err=1, no conv_done. The next full frame completes correctly with frame_err still 1.
- Async reset mid-DATA_MSB: rst_n low for 1 ns between clock edges → all outputs at reset values immediately. A new frame after release returns the correct value.
